// File: rtl/router_out_client.sv
// router_out_client: drains one router output port a packet at a time, streaming payload bytes out.
// Define CLIENT_PARITY_CHECK_EN to build the parity accumulator/comparator; otherwise parity_err is tied 0.
module router_out_client #(
  parameter int WIDTH       = 8,
  parameter int START_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [WIDTH-1:0] data_out,
  input  logic             soft_reset,
  input  logic             stall,
  output logic             read_enb,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_vld,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, WAIT, HDR_RD, HDR_CAP, BODY, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] dly_cnt;
  logic [6:0] issue_cnt, cap_cnt, hdr_cnt;
  logic cap_pend, cap, is_par, abort, par_bad, body_rd;
  assign abort   = soft_reset & (state != IDLE);
  assign hdr_cnt = {1'b0, data_out[7:2]} + 7'd1;
  assign cap     = cap_pend & ~soft_reset;
  assign is_par  = cap_cnt == 7'd1;
  assign busy    = state != IDLE;
  assign body_rd = read_enb & (state == BODY);
  always_comb begin
    read_enb = ~soft_reset & vld_out & ~stall & ((state == HDR_RD) | ((state == BODY) & (issue_cnt != '0)));
    byte_vld = cap & ~is_par;
    byte_out = byte_vld ? data_out : '0;
    state_nx = state;
    case (state)
      IDLE:    state_nx = vld_out ? ((START_DELAY == 0) ? HDR_RD : WAIT) : IDLE;
      WAIT:    state_nx = (dly_cnt == 5'd1) ? HDR_RD : WAIT;
      HDR_RD:  state_nx = read_enb ? HDR_CAP : HDR_RD;
      HDR_CAP: state_nx = BODY;
      BODY:    state_nx = (issue_cnt == {6'd0, read_enb}) ? DRAIN : BODY;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      cap_pend   <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      state     <= state_nx;
      cap_pend  <= body_rd;
      pkt_done  <= (state == DONE) & ~soft_reset;
      pkt_abort <= abort;
      if (state == IDLE) dly_cnt <= 5'(START_DELAY);
      else if (state == WAIT) dly_cnt <= dly_cnt - 5'd1;
      if (state == HDR_CAP) begin
        pkt_addr  <= data_out[1:0];
        pkt_len   <= data_out[7:2];
        issue_cnt <= hdr_cnt;
        cap_cnt   <= hdr_cnt;
      end else begin
        if (body_rd) issue_cnt <= issue_cnt - 7'd1;
        if (cap) cap_cnt <= cap_cnt - 7'd1;
      end
      if (abort) parity_err <= 1'b0;
      else if (state == DONE) parity_err <= par_bad;
    end
  end
`ifdef CLIENT_PARITY_CHECK_EN
  // Accumulator is seeded with the header; the parity capture compares instead of accumulating.
  logic [WIDTH-1:0] acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      par_bad <= 1'b0;
    end else if (state == HDR_CAP) begin
      acc     <= data_out;
      par_bad <= 1'b0;
    end else if (cap) begin
      if (is_par) par_bad <= acc != data_out;
      else acc <= acc ^ data_out;
    end
  end
`else
  assign par_bad = 1'b0;
`endif
endmodule

// File: tb/tb_router_out_client.sv
// tb_router_out_client: scoreboard bench with a port FIFO model and randomized packets/stalls.
module tb_router_out_client;
  localparam int SD = 2;
`ifdef CLIENT_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, vld_out = 1'b0, soft_reset = 1'b0, stall = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic read_enb, byte_vld, pkt_done, parity_err, pkt_abort, busy;
  logic [7:0] byte_out;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  router_out_client #(.WIDTH(8), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out), .soft_reset(soft_reset),
    .stall(stall), .read_enb(read_enb), .byte_out(byte_out), .byte_vld(byte_vld),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_done(pkt_done), .parity_err(parity_err),
    .pkt_abort(pkt_abort), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {bit abort; logic [1:0] addr; logic [5:0] len; bit perr; int t;} ev_t;
  int cyc = 0, vectors = 0, errors = 0, reads_total = 0;
  logic [7:0] q[$], exp_bytes[$], pl[$];
  ev_t exp_ev[$];
  bit force_empty = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // One clock: sample the strobe mid-cycle, then act as the port FIFO at the edge.
  task automatic tick();
    bit re;
    @(negedge clk);
    re = read_enb;
    if (re) chk("read_gate", {29'd0, stall, vld_out, soft_reset}, 32'b010);
    @(posedge clk);
    #1;
    if (re) begin
      reads_total++;
      data_out = (q.size() > 0) ? q.pop_front() : 8'h00;
    end
    vld_out = (q.size() > 0) && !force_empty;
  endtask
  // kind: 0 expect pkt_done, 1 expect pkt_abort, 2 expect neither; keep = payload bytes expected out.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] mask, input int keep, input int kind, input bit timed);
    logic [7:0] p, b;
    ev_t e;
    p = hdr;
    q.push_back(hdr);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = (i < pl.size()) ? pl[i] : 8'($urandom);
      q.push_back(b);
      p ^= b;
      if (i < keep) exp_bytes.push_back(b);
    end
    q.push_back(p ^ mask);
    pl.delete();
    e.abort = kind == 1;
    e.addr = hdr[1:0];
    e.len = hdr[7:2];
    e.perr = PCHK && (mask != 8'h00);
    e.t = timed ? cyc + int'(hdr[7:2]) + SD + 6 : -1;
    if (kind != 2) exp_ev.push_back(e);
    vld_out = !force_empty;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_ev.size() > 0 || q.size() > 0) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) chk("idle_timeout", exp_ev.size() + q.size() + busy, 0);
    repeat (2) tick();
  endtask
  always @(negedge clk) if (!reset) begin
    if (byte_vld) begin
      if (exp_bytes.size() == 0) chk("byte_unexp", exp_bytes.size(), 1);
      else chk("byte", byte_out, exp_bytes.pop_front());
    end
    if (pkt_done || pkt_abort) begin
      if (exp_ev.size() == 0) chk("ev_unexp", exp_ev.size(), 1);
      else begin
        ev_t e;
        e = exp_ev.pop_front();
        chk("ev_kind", {30'd0, pkt_done, pkt_abort}, e.abort ? 32'd1 : 32'd2);
        if (e.abort) chk("abort_busy", busy, 0);
        else begin
          chk("pkt_addr", pkt_addr, e.addr);
          chk("pkt_len", pkt_len, e.len);
          chk("parity_err", parity_err, e.perr);
          if (e.t >= 0) chk("done_time", cyc, e.t);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r0, rs;
    logic [7:0] hdr;
    repeat (3) tick();
    chk("rst_outs", {read_enb, byte_vld, pkt_done, parity_err, pkt_abort, busy, byte_out, pkt_addr, pkt_len}, 0);
    reset = 1'b0;
    repeat (2) tick();
    // Good and bad parity on the reference packet.
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 8'h00, 64, 0, 1'b1);
    wait_idle();
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 8'h0D, 64, 0, 1'b1);
    wait_idle();
    // Reset landing in DRAIN of a len-2 packet.
    send_pkt(8'h0A, 8'h00, 64, 2, 1'b0);
    r0 = cyc;
    while (cyc < r0 + SD + 6) tick();
    reset = 1'b1;
    tick();
    chk("drain_rst", {read_enb, byte_vld, pkt_done, parity_err, pkt_abort, busy, byte_out, pkt_addr, pkt_len}, 0);
    reset = 1'b0;
    q.delete();
    vld_out = 1'b0;
    repeat (10) tick();
    // Zero-length packet: header plus parity only.
    r0 = reads_total;
    send_pkt(8'h02, 8'h00, 64, 0, 1'b1);
    wait_idle();
    chk("len0_reads", reads_total - r0, 2);
    // Len-4 with a 5-cycle stall and a 3-cycle empty FIFO.
    r0 = reads_total;
    send_pkt(8'h12, 8'h00, 64, 0, 1'b0);
    for (int i = 0; i < 100 && reads_total - r0 < 3; i++) tick();
    stall = 1'b1;
    rs = reads_total;
    repeat (5) tick();
    chk("stall_hold", reads_total - rs, 0);
    stall = 1'b0;
    for (int i = 0; i < 100 && reads_total - r0 < 4; i++) tick();
    force_empty = 1'b1;
    vld_out = 1'b0;
    rs = reads_total;
    repeat (3) tick();
    chk("empty_hold", reads_total - rs, 0);
    force_empty = 1'b0;
    vld_out = q.size() > 0;
    wait_idle();
    chk("len4_reads", reads_total - r0, 6);
    // Soft reset after two of five payload bytes.
    r0 = reads_total;
    send_pkt(8'h17, 8'h00, 2, 1, 1'b0);
    for (int i = 0; i < 100 && reads_total - r0 < 3; i++) tick();
    stall = 1'b1;
    repeat (2) tick();
    stall = 1'b0;
    soft_reset = 1'b1;
    #1;
    chk("sr_gate", read_enb, 0);
    tick();
    soft_reset = 1'b0;
    q.delete();
    vld_out = 1'b0;
    wait_idle();
    pl = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(8'h0D, 8'h00, 64, 0, 1'b1);
    wait_idle();
    // Randomized back-to-back traffic with sporadic stall and empty gaps.
    for (int n = 0; n < 40; n++) begin
      hdr = {6'($urandom_range(0, 12)), 2'($urandom_range(0, 2))};
      send_pkt(hdr, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 64, 0, 1'b0);
      repeat ($urandom_range(0, 15)) begin
        stall = $urandom_range(0, 4) == 0;
        force_empty = $urandom_range(0, 7) == 0;
        tick();
      end
    end
    stall = 1'b0;
    force_empty = 1'b0;
    vld_out = q.size() > 0;
    wait_idle();
    chk("leftover", exp_bytes.size() + exp_ev.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
